qoa_slice_sequencer: RTL
========================

# qoa_slice_sequencer

Command sequencer between the synchronised SPI byte stream and the QOA decoder datapath. Parses host command bytes and loads LMS state (history/weights) into the decoder. Unpacks 64-bit QOA slices into scale factor plus twenty 3-bit residuals and steps the decoder one sample at a time. Returns each decoded 16-bit sample to the SPI transmit path as two bytes, MSB byte first.

## Interface
- No parameters; the QOA format fixes all widths.
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  reset, asynchronous, active-high
- rx_valid  in  1  one-cycle pulse: rx_byte holds a new SPI byte
- rx_byte  in  8  received byte
- lms_wr  out  1  one-cycle write strobe to the decoder LMS register file
- lms_idx  out  3  0-3 = history[0..3], 4-7 = weights[0..3]
- lms_data  out  16  signed LMS word
- dec_valid  out  1  decode request, held until accepted
- dec_sf  out  4  slice scale factor
- dec_res  out  3  current quantised residual
- dec_done  in  1  decoder accepts the request; dec_sample is valid this cycle
- dec_sample  in  16  decoded, clamped sample
- tx_valid  out  1  tx_byte is valid, held until tx_ready
- tx_byte  out  8  byte toward SPI TX
- tx_ready  in  1  TX side accepts tx_byte
- busy  out  1  high in every state except IDLE
- rx_overrun  out  1  sticky: a byte was dropped while in DEC/SEND_HI/SEND_LO

## Operation
- States: IDLE, LMS_LOAD, SLICE_LOAD, DEC, SEND_HI, SEND_LO.
- IDLE command bytes:
  - 0x00 clears rx_overrun.
  - 0x01 enters LMS_LOAD with byte count 0.
  - 0x02 enters SLICE_LOAD with byte count 0.
  - Any other value is ignored.
- LMS_LOAD: accepts 16 bytes as 8 big-endian words, in order history0-3 then weights0-3.
  - After each odd byte (2nd, 4th, ...), lms_data = {hi, lo} and lms_idx = word number, with lms_wr pulsed.
  - After the 8th word, return to IDLE.
- SLICE_LOAD: shifts 8 bytes MSB-first into a 64-bit slice register.
  - After the 8th byte, dec_sf = slice[63:60] and residual index r = 0. Go to DEC.
- DEC: dec_valid = 1, dec_res = slice[59-3r -: 3].
  - On dec_done, capture dec_sample, drop dec_valid, go to SEND_HI.
- SEND_HI: tx_byte = sample[15:8], tx_valid = 1. On tx_ready, go to SEND_LO.
- SEND_LO: tx_byte = sample[7:0].
  - On tx_ready with r = 19, go to IDLE.
  - Otherwise r = r+1 and go to DEC.
- Residual index r is 5 bits and ranges 0-19; it never wraps past 19.
- rx_valid in DEC/SEND_HI/SEND_LO: the byte is discarded and rx_overrun is set. It stays set until command 0x00 or reset.
- rx_valid in IDLE/LMS_LOAD/SLICE_LOAD: the byte is always consumed. There is no backpressure on RX.

## Timing
- Reset values: state IDLE, all counters 0, and lms_wr, lms_idx, lms_data, dec_valid, dec_sf, dec_res, tx_valid, tx_byte, busy, rx_overrun all 0.
- Reset mid-operation aborts immediately. A partial LMS word or slice is discarded, and no further lms_wr, dec_valid or tx_valid appears.
- rx_valid is sampled on the clk edge; the state or counter update is visible the next cycle.
- lms_wr is high the cycle after the edge that captured the word's low byte, for exactly one cycle.
- DEC is entered the cycle after the 8th slice byte is captured. dec_valid is registered, so it rises that cycle.
- dec_done is honoured only while dec_valid = 1, including the first dec_valid cycle. dec_valid falls the next cycle.
- Per-sample minimum latency: 1 DEC cycle (dec_done immediate) + 1 SEND_HI + 1 SEND_LO = 3 cycles. A full slice takes at least 60 cycles after the last slice byte.
- tx_byte is stable while tx_valid = 1 and tx_ready = 0. The transfer completes on the edge where both are high.
- Command 0x00 arriving with rx_valid at the same edge an overrun is flagged cannot happen: 0x00 is only decoded in IDLE, where no overrun is flagged.

## Test plan
- Reset then LMS load: IDLE cmd 0x01 + bytes 00 01 00 02 00 03 00 04 20 00 E0 00 00 00 00 00 -> eight lms_wr pulses with (idx, data) = (0,0x0001), (1,0x0002), (2,0x0003), (3,0x0004), (4,0x2000), (5,0xE000), (6,0), (7,0). Then busy = 0.
- Slice unpack: cmd 0x02 + 0x5 in bits[63:60], residuals r_i = i mod 8 -> dec_sf = 5 and dec_res sequence 0,1,...,7,0,...,3 over 20 requests.
- Sample return with stalls: dec_sample = 0x8A3C, tx_ready low for 3 cycles -> tx_byte held at 0x8A for 3 cycles, then 0x3C. The 20th sample completes and the block returns to IDLE.
- Zero-latency handshakes: dec_done and tx_ready tied high -> exactly 60 cycles from the first dec_valid to IDLE.
- Overrun: byte 0x77 during DEC -> rx_overrun = 1, state and outputs unaffected. Later cmd 0x00 in IDLE -> rx_overrun = 0.
- Async reset at r = 7 in SEND_HI -> tx_valid, dec_valid and busy go to 0 without a clock edge. A following cmd 0x02 slice restarts at r = 0.

Source files
------------

// File: rtl/qoa_slice_sequencer.sv
// Sequencer between the SPI byte stream and the QOA decoder: parses host commands,
// loads LMS state, unpacks 64-bit slices into residuals and returns samples as byte pairs.
module qoa_slice_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        lms_wr,
    output logic [2:0]  lms_idx,
    output logic [15:0] lms_data,
    output logic        dec_valid,
    output logic [3:0]  dec_sf,
    output logic [2:0]  dec_res,
    input  logic        dec_done,
    input  logic [15:0] dec_sample,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    output logic        busy,
    output logic        rx_overrun
);

    localparam int unsigned NUM_RES = 20;
    localparam int unsigned RES_W   = 3;
    localparam int unsigned BODY_W  = NUM_RES * RES_W;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LMS_LOAD   = 3'd1;
    localparam logic [2:0] S_SLICE_LOAD = 3'd2;
    localparam logic [2:0] S_DEC        = 3'd3;
    localparam logic [2:0] S_SEND_HI    = 3'd4;
    localparam logic [2:0] S_SEND_LO    = 3'd5;

    localparam logic [7:0] CMD_CLR   = 8'h00;
    localparam logic [7:0] CMD_LMS   = 8'h01;
    localparam logic [7:0] CMD_SLICE = 8'h02;

    localparam logic [4:0] LAST_RES  = 5'(NUM_RES - 1);

    logic [2:0]        r_state,     w_state;
    logic [3:0]        r_cnt,       w_cnt;
    logic [7:0]        r_hi,        w_hi;
    logic [BODY_W-1:0] r_slice,     w_slice;
    logic [4:0]        r_ridx,      w_ridx;
    logic [7:0]        r_sample_lo, w_sample_lo;
    logic              r_lms_wr,    w_lms_wr;
    logic [2:0]        r_lms_idx,   w_lms_idx;
    logic [15:0]       r_lms_data,  w_lms_data;
    logic              r_dec_valid, w_dec_valid;
    logic [3:0]        r_dec_sf,    w_dec_sf;
    logic              r_tx_valid,  w_tx_valid;
    logic [7:0]        r_tx_byte,   w_tx_byte;
    logic              r_busy,      w_busy;
    logic              r_overrun,   w_overrun;

    // Slice body register: the current residual always sits in the top three bits,
    // so it doubles as the registered dec_res output. During loading it holds the
    // low 60 bits of the byte shift; the scale factor is peeled off on the last byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_hi        <= 8'd0;
            r_slice     <= '0;
            r_ridx      <= 5'd0;
            r_sample_lo <= 8'd0;
            r_lms_wr    <= 1'b0;
            r_lms_idx   <= 3'd0;
            r_lms_data  <= 16'd0;
            r_dec_valid <= 1'b0;
            r_dec_sf    <= 4'd0;
            r_tx_valid  <= 1'b0;
            r_tx_byte   <= 8'd0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_hi        <= w_hi;
            r_slice     <= w_slice;
            r_ridx      <= w_ridx;
            r_sample_lo <= w_sample_lo;
            r_lms_wr    <= w_lms_wr;
            r_lms_idx   <= w_lms_idx;
            r_lms_data  <= w_lms_data;
            r_dec_valid <= w_dec_valid;
            r_dec_sf    <= w_dec_sf;
            r_tx_valid  <= w_tx_valid;
            r_tx_byte   <= w_tx_byte;
            r_busy      <= w_busy;
            r_overrun   <= w_overrun;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_hi        = r_hi;
        w_slice     = r_slice;
        w_ridx      = r_ridx;
        w_sample_lo = r_sample_lo;
        w_lms_wr    = 1'b0;
        w_lms_idx   = r_lms_idx;
        w_lms_data  = r_lms_data;
        w_dec_valid = r_dec_valid;
        w_dec_sf    = r_dec_sf;
        w_tx_valid  = r_tx_valid;
        w_tx_byte   = r_tx_byte;
        w_overrun   = r_overrun;

        case (r_state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_byte)
                        CMD_CLR:   w_overrun = 1'b0;
                        CMD_LMS: begin
                            w_state = S_LMS_LOAD;
                            w_cnt   = 4'd0;
                        end
                        CMD_SLICE: begin
                            w_state = S_SLICE_LOAD;
                            w_cnt   = 4'd0;
                        end
                        default: ;
                    endcase
                end
            end
            S_LMS_LOAD: begin
                if (rx_valid) begin
                    w_cnt = r_cnt + 4'd1;
                    if (!r_cnt[0]) begin
                        w_hi = rx_byte;
                    end else begin
                        w_lms_wr   = 1'b1;
                        w_lms_idx  = r_cnt[3:1];
                        w_lms_data = {r_hi, rx_byte};
                        if (r_cnt == 4'd15) begin
                            w_state = S_IDLE;
                        end
                    end
                end
            end
            S_SLICE_LOAD: begin
                if (rx_valid) begin
                    w_cnt   = r_cnt + 4'd1;
                    w_slice = {r_slice[BODY_W-9:0], rx_byte};
                    if (r_cnt == 4'd7) begin
                        w_dec_sf    = r_slice[BODY_W-5:BODY_W-8];
                        w_ridx      = 5'd0;
                        w_dec_valid = 1'b1;
                        w_state     = S_DEC;
                    end
                end
            end
            S_DEC: begin
                if (rx_valid) begin
                    w_overrun = 1'b1;
                end
                if (dec_done && r_dec_valid) begin
                    w_sample_lo = dec_sample[7:0];
                    w_dec_valid = 1'b0;
                    w_tx_valid  = 1'b1;
                    w_tx_byte   = dec_sample[15:8];
                    w_state     = S_SEND_HI;
                end
            end
            S_SEND_HI: begin
                if (rx_valid) begin
                    w_overrun = 1'b1;
                end
                if (tx_ready) begin
                    w_tx_byte = r_sample_lo;
                    w_state   = S_SEND_LO;
                end
            end
            S_SEND_LO: begin
                if (rx_valid) begin
                    w_overrun = 1'b1;
                end
                if (tx_ready) begin
                    w_tx_valid = 1'b0;
                    if (r_ridx == LAST_RES) begin
                        w_state = S_IDLE;
                    end else begin
                        w_ridx      = r_ridx + 5'd1;
                        w_slice     = {r_slice[BODY_W-RES_W-1:0], {RES_W{1'b0}}};
                        w_dec_valid = 1'b1;
                        w_state     = S_DEC;
                    end
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign lms_wr     = r_lms_wr;
    assign lms_idx    = r_lms_idx;
    assign lms_data   = r_lms_data;
    assign dec_valid  = r_dec_valid;
    assign dec_sf     = r_dec_sf;
    assign dec_res    = r_slice[BODY_W-1:BODY_W-RES_W];
    assign tx_valid   = r_tx_valid;
    assign tx_byte    = r_tx_byte;
    assign busy       = r_busy;
    assign rx_overrun = r_overrun;

endmodule
